// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern mode encodings, colour-bar table and default 640x480 timing.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BLACK = 2'd3
    } mode_t;

    localparam int unsigned DEF_TOTAL_COLS  = 800;
    localparam int unsigned DEF_TOTAL_ROWS  = 525;
    localparam int unsigned DEF_ACTIVE_COLS = 640;
    localparam int unsigned DEF_ACTIVE_ROWS = 480;

    // {R,G,B} on/off flags: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic logic [2:0] bar_color(input logic [2:0] idx);
        return BAR_RGB[idx];
    endfunction

endpackage

// File: rtl/vga_sync_to_count.sv
// Column/row position tracker: resyncs on each rising VSync and wraps over the full frame.
module vga_sync_to_count #(
    parameter int unsigned TOTAL_COLS = 800,
    parameter int unsigned TOTAL_ROWS = 525
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    input  logic                          i_VSync,
    output logic                          o_Frame_Start,
    output logic                          o_Synced,
    output logic [$clog2(TOTAL_COLS)-1:0] o_Col,
    output logic [$clog2(TOTAL_ROWS)-1:0] o_Row
);
    localparam int unsigned CW = $clog2(TOTAL_COLS);
    localparam int unsigned RW = $clog2(TOTAL_ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(TOTAL_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(TOTAL_ROWS - 1);

    logic vs_prev;
    logic primed;

    // vs_prev only reflects a real sample once primed, so a VSync held high
    // across reset is not mistaken for a frame start.
    always_comb begin
        o_Frame_Start = primed & ~vs_prev & i_VSync;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            vs_prev  <= 1'b0;
            primed   <= 1'b0;
            o_Synced <= 1'b0;
            o_Col    <= '0;
            o_Row    <= '0;
        end else begin
            vs_prev <= i_VSync;
            primed  <= 1'b1;
            if (o_Frame_Start) begin
                o_Col    <= '0;
                o_Row    <= '0;
                o_Synced <= 1'b1;
            end else if (o_Synced) begin
                if (o_Col == COL_LAST) begin
                    o_Col <= '0;
                    o_Row <= (o_Row == ROW_LAST) ? '0 : o_Row + 1'b1;
                end else begin
                    o_Col <= o_Col + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_color_out.sv
// Two-stage VGA colour output: registers inputs and position, then selects the
// frame-latched pattern and blanks outside the active region.
module vga_color_out
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_BITS  = 3,
    parameter int unsigned TOTAL_COLS  = DEF_TOTAL_COLS,
    parameter int unsigned TOTAL_ROWS  = DEF_TOTAL_ROWS,
    parameter int unsigned ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int unsigned ACTIVE_ROWS = DEF_ACTIVE_ROWS,
    parameter int unsigned CHECK_LOG2  = 5
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    input  logic                          i_HSync,
    input  logic                          i_VSync,
    input  logic [COLOR_BITS-1:0]         i_Red,
    input  logic [COLOR_BITS-1:0]         i_Grn,
    input  logic [COLOR_BITS-1:0]         i_Blu,
    input  logic [1:0]                    i_Mode,
    output logic                          o_HSync,
    output logic                          o_VSync,
    output logic [COLOR_BITS-1:0]         o_Red,
    output logic [COLOR_BITS-1:0]         o_Grn,
    output logic [COLOR_BITS-1:0]         o_Blu,
    output logic [$clog2(TOTAL_COLS)-1:0] o_Col,
    output logic [$clog2(TOTAL_ROWS)-1:0] o_Row
);
    localparam int unsigned CW    = $clog2(TOTAL_COLS);
    localparam int unsigned RW    = $clog2(TOTAL_ROWS);
    localparam int unsigned BAR_W = ACTIVE_COLS / 8;

    if (COLOR_BITS < 1 || COLOR_BITS > 8 || ACTIVE_COLS % 8 != 0 ||
        ACTIVE_COLS > TOTAL_COLS || ACTIVE_ROWS > TOTAL_ROWS) begin : g_bad_geometry
        $error("vga_color_out: illegal colour depth or frame geometry");
    end

    logic                  hs1, vs1;
    logic [COLOR_BITS-1:0] red1, grn1, blu1;
    logic                  frame_start, synced;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    mode_t                 frame_mode;

    logic                  active;
    logic [2:0]            bar_idx;
    logic [2:0]            bar_rgb;
    logic                  check_on;
    logic [COLOR_BITS-1:0] sel_red, sel_grn, sel_blu;

    vga_sync_to_count #(
        .TOTAL_COLS(TOTAL_COLS),
        .TOTAL_ROWS(TOTAL_ROWS)
    ) u_count (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .i_VSync       (i_VSync),
        .o_Frame_Start (frame_start),
        .o_Synced      (synced),
        .o_Col         (col),
        .o_Row         (row)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hs1        <= 1'b0;
            vs1        <= 1'b0;
            red1       <= '0;
            grn1       <= '0;
            blu1       <= '0;
            frame_mode <= MODE_PASS;
        end else begin
            hs1  <= i_HSync;
            vs1  <= i_VSync;
            red1 <= i_Red;
            grn1 <= i_Grn;
            blu1 <= i_Blu;
            if (frame_start) begin
                frame_mode <= mode_t'(i_Mode);
            end
        end
    end

    // Colour stays black after reset until the counters have resynced to a frame start.
    always_comb begin
        active  = hs1 & vs1 & synced;
        bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (32'(col) >= k * BAR_W) begin
                bar_idx = 3'(k);
            end
        end
        bar_rgb  = bar_color(bar_idx);
        check_on = (|((col >> CHECK_LOG2) & CW'(1))) ^ (|((row >> CHECK_LOG2) & RW'(1)));

        sel_red = '0;
        sel_grn = '0;
        sel_blu = '0;
        case (frame_mode)
            MODE_PASS: begin
                sel_red = red1;
                sel_grn = grn1;
                sel_blu = blu1;
            end
            MODE_BARS: begin
                sel_red = {COLOR_BITS{bar_rgb[2]}};
                sel_grn = {COLOR_BITS{bar_rgb[1]}};
                sel_blu = {COLOR_BITS{bar_rgb[0]}};
            end
            MODE_CHECK: begin
                sel_red = {COLOR_BITS{check_on}};
                sel_grn = {COLOR_BITS{check_on}};
                sel_blu = {COLOR_BITS{check_on}};
            end
            default: begin
                sel_red = '0;
                sel_grn = '0;
                sel_blu = '0;
            end
        endcase

        if (!active) begin
            sel_red = '0;
            sel_grn = '0;
            sel_blu = '0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_HSync <= 1'b0;
            o_VSync <= 1'b0;
            o_Red   <= '0;
            o_Grn   <= '0;
            o_Blu   <= '0;
            o_Col   <= '0;
            o_Row   <= '0;
        end else begin
            o_HSync <= hs1;
            o_VSync <= vs1;
            o_Red   <= sel_red;
            o_Grn   <= sel_grn;
            o_Blu   <= sel_blu;
            o_Col   <= col;
            o_Row   <= row;
        end
    end

endmodule

// File: doc/vga_color_out.md
# vga_color_out

Registered, parametrised VGA colour output stage with selectable pattern source. Sits between the sync-pulse/porch logic and the board's VGA DAC pins. It tracks column/row position from the incoming active-region sync signals and chooses pixel data per a frame-latched mode: pass-through, colour bars, checkerboard or forced black. Colour outside the active region is forced to zero, and the syncs are delayed to stay aligned with the colour pipeline.

## Interface
Parameters:
- COLOR_BITS, 3, bits per colour channel (1..8)
- TOTAL_COLS, 800, clocks per line including blanking
- TOTAL_ROWS, 525, lines per frame including blanking
- ACTIVE_COLS, 640, visible columns; must be a multiple of 8
- ACTIVE_ROWS, 480, visible rows
- CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels

Ports:
- i_Clk  in  1  pixel clock
- i_Rst_L  in  1  asynchronous, active-low reset
- i_HSync  in  1  high during active columns of a line
- i_VSync  in  1  high during active rows of a frame
- i_Red / i_Grn / i_Blu  in  COLOR_BITS each  pass-through pixel data, aligned with i_HSync/i_VSync
- i_Mode  in  2  0 = pass-through, 1 = colour bars, 2 = checkerboard, 3 = black
- o_HSync / o_VSync  out  1  i_HSync/i_VSync delayed 2 clocks
- o_Red / o_Grn / o_Blu  out  COLOR_BITS each  registered colour
- o_Col / o_Row  out  $clog2(TOTAL_COLS) / $clog2(TOTAL_ROWS)  position of the pixel currently on o_Red etc.

## Operation
- Reset (async assert, sync release): all outputs 0, counters 0, latched mode 0, pipeline registers 0.
- Frame start = rising edge of i_VSync (registered previous value 0, current 1). On that clock: col = 0, row = 0, and i_Mode is latched as the frame mode.
- Otherwise col increments each clock. At col = TOTAL_COLS-1, col wraps to 0 and row increments. At row = TOTAL_ROWS-1 with col wrapping, row wraps to 0.
- Frame start overrides wrap on the same clock.
- The mode is only sampled at frame start. Mode changes mid-frame have no effect until the next frame.
- active = stage-1 HSync AND stage-1 VSync.
- Colour selection:
  - Mode 0: registered input colour.
  - Mode 1: 8 bars of width ACTIVE_COLS/8, indexed by col. Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black. A channel that is "on" is all ones; "off" is 0.
  - Mode 2: white when col[CHECK_LOG2] XOR row[CHECK_LOG2] is 1, else black.
  - Mode 3: all zero.
- Output colour = selected colour if active, else 0. Blanking is always black, in all modes.
- Bar index beyond 7 (col ≥ ACTIVE_COLS while active is inconsistent) is clamped to 7 (black).

## Timing
- Stage 1 (clock N+1): input syncs, colour and counters registered.
- Stage 2 (clock N+2): pattern select and blank gating registered onto the outputs.
- Latency: input at edge N appears on o_* at edge N+2. o_HSync/o_VSync use the same 2-clock delay, so colour and sync stay aligned.
- o_Col/o_Row are delayed so they label the pixel on the outputs.
- Frame-mode change takes effect on the first pixel of the new frame, 2 clocks after i_VSync rises.
- Reset asserted mid-line: outputs go to 0 immediately (async). After release, outputs stay 0 and counters hold at 0 until the next frame start, which is the only resync point.
- No back-pressure. The block accepts one pixel per clock unconditionally.

## Structure
- Shared package vga_pkg holds:
  - the mode encodings (MODE_PASS, MODE_BARS, MODE_CHECK, MODE_BLACK);
  - the 8-entry bar colour table as 3-bit RGB on/off flags;
  - the default 640x480 timing constants.
- One natural sub-module: vga_sync_to_count, which does the VSync edge detect and the col/row counters with wrap. It is reusable by the sprite and text blocks.
- Pattern select and gating stay in the top level.

## Test plan
- Reset, then stream pass-through with i_Red=3'b101, i_Grn=3'b010, i_Blu=3'b111 and both syncs high → same value on outputs exactly 2 clocks later; o_HSync/o_VSync follow with the same delay.
- Pass-through with i_HSync=0 and colour 3'b111 on all channels → outputs 0 (black during blanking).
- Mode 1, full frame → at col 0 output 111/111/111; col 80 gives 111/111/000; col 560 gives 000/000/000; every boundary at multiples of 80.
- Mode 2 → pixel (col 0, row 0) is black, (32, 0) white, (32, 32) black, (0, 32) white.
- Switch i_Mode 0→3 at row 100 → rest of frame stays pass-through; the next frame, after the i_VSync rise, is all black.
- Assert i_Rst_L low mid-line → outputs 0 within the same clock. After release, outputs stay 0 with counters at 0 until the next i_VSync rise, then col/row start from 0.
